reg_hazard_ctrl: RTL and testbench
==================================

# reg_hazard_ctrl

Load scoreboard and writeback-port arbiter for `register_file`. Tracks registers with outstanding variable-latency loads and stalls issue on RAW/WAW hazards against them. Shares the single writeback port (`write_addr`/`write_data`) between load returns and ALU results using one-cycle fairness. The registered writeback output feeds the register file, whose mem-stage forwarding makes the value visible to readers in the cycle after acceptance.

## Interface
- `MAX_LOADS`, default 4: maximum outstanding loads (1..15).
- `CNT_W`, default 3: width of the outstanding counter; must satisfy `2^CNT_W > MAX_LOADS`.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `issue_valid` in 1: decode presents an instruction.
- `issue_is_load` in 1: instruction is a load.
- `issue_dst` in 4: destination register; 0 means no write.
- `issue_src_a`, `issue_src_b`, `issue_src_m`, `issue_src_p` in 4 each: source registers; 0 never hazards.
- `issue_stall` out 1: combinational; instruction must be held.
- `ld_ret_valid` in 1: load data returning.
- `ld_ret_addr` in 4, `ld_ret_data` in 32: load destination and data.
- `ld_ret_ready` out 1: combinational; load return accepted this cycle.
- `alu_wb_valid` in 1: ALU result wants the writeback port.
- `alu_wb_addr` in 4, `alu_wb_data` in 32: ALU destination and data.
- `alu_wb_ready` out 1: combinational; ALU result accepted this cycle.
- `write_addr` out 4, `write_data` out 32: registered writeback to `register_file`.
- `pending` out 16: registered scoreboard bitmap; bit 0 is always 0.
- `outstanding` out CNT_W: registered count of loads in flight.
- `ret_err` out 1: sticky; a load returned to a non-pending nonzero register.

## Operation
- Load accept: `issue_valid & ~issue_stall & issue_is_load`.
  - Sets `pending[issue_dst]` when `issue_dst != 0`.
  - Increments `outstanding`.
- `issue_stall = issue_valid & (any nonzero src with pending bit set | (issue_dst != 0 & pending[issue_dst]) | (issue_is_load & outstanding == MAX_LOADS))`.
- The stall uses registered `pending` only. A clear in the same cycle does not unstall until the next cycle.
- Arbitration, using state bit `alu_owed`:
  - Only one requester valid: that requester wins.
  - Both valid and `alu_owed = 0`: the load wins and `alu_owed` is set to 1.
  - Both valid and `alu_owed = 1`: the ALU wins and `alu_owed` is cleared.
  - `alu_owed` is also cleared whenever the ALU is accepted, or when `alu_wb_valid` is low.
- Load return accept (`ld_ret_valid & ld_ret_ready`):
  - `write_addr <= ld_ret_addr`, `write_data <= ld_ret_data`.
  - Clears `pending[ld_ret_addr]`.
  - Decrements `outstanding`.
  - If `ld_ret_addr != 0` and its pending bit is 0, sets `ret_err`; the write still occurs.
- Load return to address 0: accepted, counter decremented, no register write.
- ALU accept: `write_addr <= alu_wb_addr`, `write_data <= alu_wb_data`. Scoreboard unchanged.
- No accept in a cycle: `write_addr <= 0`, `write_data <= 0`.
- Load accept and return accept in the same cycle: `outstanding` unchanged.
  - A set and a clear of the same bit cannot coincide, because WAW stalls the issue.
- Return with `outstanding == 0`: the counter saturates at 0 and `ret_err` is set.

## Timing
- Reset values: `pending = 0`, `outstanding = 0`, `write_addr = 0`, `write_data = 0`, `ret_err = 0`, `alu_owed = 0`.
- Reset asserted mid-flight discards all outstanding loads. Returns arriving after reset are treated as errors.
- `issue_stall`, `ld_ret_ready` and `alu_wb_ready` are combinational from inputs and state. There is no path from `ready` back to `valid`.
- Writeback latency: accepted in cycle N, so `write_addr`/`write_data` are valid in cycle N+1 and the register file writes at the end of N+1.
- Scoreboard latency: a pending bit is cleared at the end of accept cycle N. A dependent instruction unstalls in N+1 and receives the data via register-file writeback forwarding.
- Requesters hold valid and payload stable until accepted.

## Test plan
- Reset, then issue load dst=5. Next cycle: `pending = 16'h0020`, `outstanding = 1`. An instruction with `src_a = 5` has `issue_stall = 1`; `src_a = 0` or `src_a = 6` gives stall 0.
- Return addr=5, data=32'hDEADBEEF, with no ALU request. `ld_ret_ready = 1`. Next cycle: `write_addr = 5`, `write_data = 32'hDEADBEEF`, `pending = 0`, and the dependent instruction unstalls.
- Issue 4 loads to r1..r4, then a 5th load to r6: `issue_stall = 1`. A non-load to r6 does not stall. After one return, the 5th load is accepted.
- Load return and ALU request both valid for 4 cycles: accept order is load, ALU, load, ALU. `write_addr` follows that order one cycle later.
- Return to r9 while it is not pending: `ret_err = 1` and stays set, `write_addr = 9` next cycle. Return to r0: `write_addr = 0` next cycle, `outstanding` decremented.
- Assert `rst_n = 0` with 3 loads outstanding: outputs clear immediately (asynchronously); after release, `pending = 0` and `outstanding = 0`.

Source files
------------

// File: rtl/reg_hazard_ctrl.sv
// Load scoreboard and writeback-port arbiter in front of register_file.
// Stalls issue on RAW/WAW against in-flight loads and alternates the shared write port fairly.
module reg_hazard_ctrl #(
    parameter int MAX_LOADS = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic             issue_is_load,
    input  logic [3:0]       issue_dst,
    input  logic [3:0]       issue_src_a,
    input  logic [3:0]       issue_src_b,
    input  logic [3:0]       issue_src_m,
    input  logic [3:0]       issue_src_p,
    output logic             issue_stall,
    input  logic             ld_ret_valid,
    input  logic [3:0]       ld_ret_addr,
    input  logic [31:0]      ld_ret_data,
    output logic             ld_ret_ready,
    input  logic             alu_wb_valid,
    input  logic [3:0]       alu_wb_addr,
    input  logic [31:0]      alu_wb_data,
    output logic             alu_wb_ready,
    output logic [3:0]       write_addr,
    output logic [31:0]      write_data,
    output logic [15:0]      pending,
    output logic [CNT_W-1:0] outstanding,
    output logic             ret_err
);

    logic [15:0]      pending_q, pending_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [3:0]       write_addr_q, write_addr_d;
    logic [31:0]      write_data_q, write_data_d;
    logic             ret_err_q, ret_err_d;
    logic             alu_owed_q, alu_owed_d;
    logic             ld_issue_acc;
    logic             ld_ret_acc;
    logic             src_hazard;
    logic             dst_hazard;
    logic             cap_hazard;

    function automatic logic src_hz(input logic [15:0] pend, input logic [3:0] s);
        return (s != 4'd0) && pend[s];
    endfunction

    // Hazards look only at registered state so a same-cycle clear unstalls one cycle later.
    always_comb begin
        src_hazard  = src_hz(pending_q, issue_src_a) | src_hz(pending_q, issue_src_b) |
                      src_hz(pending_q, issue_src_m) | src_hz(pending_q, issue_src_p);
        dst_hazard  = src_hz(pending_q, issue_dst);
        cap_hazard  = issue_is_load && (outstanding_q == CNT_W'(MAX_LOADS));
        issue_stall = issue_valid & (src_hazard | dst_hazard | cap_hazard);

        ld_ret_ready = ld_ret_valid & (~alu_wb_valid | ~alu_owed_q);
        alu_wb_ready = alu_wb_valid & (~ld_ret_valid | alu_owed_q);
        alu_owed_d   = ld_ret_valid & alu_wb_valid & ~alu_owed_q;

        ld_issue_acc = issue_valid & ~issue_stall & issue_is_load;
        ld_ret_acc   = ld_ret_valid & ld_ret_ready;
    end

    always_comb begin
        pending_d     = pending_q;
        outstanding_d = outstanding_q;
        ret_err_d     = ret_err_q;
        write_addr_d  = 4'd0;
        write_data_d  = 32'd0;

        if (ld_ret_acc) begin
            write_addr_d            = ld_ret_addr;
            write_data_d            = ld_ret_data;
            pending_d[ld_ret_addr]  = 1'b0;
            if (((ld_ret_addr != 4'd0) && !pending_q[ld_ret_addr]) ||
                (outstanding_q == '0))
                ret_err_d = 1'b1;
        end else if (alu_wb_ready) begin
            write_addr_d = alu_wb_addr;
            write_data_d = alu_wb_data;
        end

        if (ld_issue_acc && (issue_dst != 4'd0))
            pending_d[issue_dst] = 1'b1;
        pending_d[0] = 1'b0;

        // Simultaneous issue and return cancel; a stray return saturates at zero.
        if (ld_issue_acc && !ld_ret_acc)
            outstanding_d = outstanding_q + CNT_W'(1);
        else if (!ld_issue_acc && ld_ret_acc && (outstanding_q != '0))
            outstanding_d = outstanding_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            write_addr_q  <= '0;
            write_data_q  <= '0;
            ret_err_q     <= 1'b0;
            alu_owed_q    <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            write_addr_q  <= write_addr_d;
            write_data_q  <= write_data_d;
            ret_err_q     <= ret_err_d;
            alu_owed_q    <= alu_owed_d;
        end
    end

    assign pending     = pending_q;
    assign outstanding = outstanding_q;
    assign write_addr  = write_addr_q;
    assign write_data  = write_data_q;
    assign ret_err     = ret_err_q;

endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// Directed self-checking bench for reg_hazard_ctrl with hand-computed expectations.
module tb_reg_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_is_load;
    logic [3:0]  issue_dst, issue_src_a, issue_src_b, issue_src_m, issue_src_p;
    logic        issue_stall;
    logic        ld_ret_valid;
    logic [3:0]  ld_ret_addr;
    logic [31:0] ld_ret_data;
    logic        ld_ret_ready;
    logic        alu_wb_valid;
    logic [3:0]  alu_wb_addr;
    logic [31:0] alu_wb_data;
    logic        alu_wb_ready;
    logic [3:0]  write_addr;
    logic [31:0] write_data;
    logic [15:0] pending;
    logic [2:0]  outstanding;
    logic        ret_err;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    reg_hazard_ctrl #(.MAX_LOADS(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_is_load(issue_is_load), .issue_dst(issue_dst),
        .issue_src_a(issue_src_a), .issue_src_b(issue_src_b),
        .issue_src_m(issue_src_m), .issue_src_p(issue_src_p),
        .issue_stall(issue_stall),
        .ld_ret_valid(ld_ret_valid), .ld_ret_addr(ld_ret_addr), .ld_ret_data(ld_ret_data),
        .ld_ret_ready(ld_ret_ready),
        .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
        .alu_wb_ready(alu_wb_ready),
        .write_addr(write_addr), .write_data(write_data),
        .pending(pending), .outstanding(outstanding), .ret_err(ret_err)
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge so registered outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic ld, input logic [3:0] dst,
                                 input logic [3:0] sa);
        issue_valid   = v;
        issue_is_load = ld;
        issue_dst     = dst;
        issue_src_a   = sa;
        #1;
    endtask

    task automatic setReturn(input logic v, input logic [3:0] a, input logic [31:0] d);
        ld_ret_valid = v;
        ld_ret_addr  = a;
        ld_ret_data  = d;
    endtask

    task automatic setAlu(input logic v, input logic [3:0] a, input logic [31:0] d);
        alu_wb_valid = v;
        alu_wb_addr  = a;
        alu_wb_data  = d;
    endtask

    initial begin
        rst_n = 1'b0;
        issue_src_b = 4'd0; issue_src_m = 4'd0; issue_src_p = 4'd0;
        setReturn(1'b0, 4'd0, 32'd0);
        setAlu(1'b0, 4'd0, 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
        #22;
        checkOutput("rst_pending", 32'(pending), 32'h0);
        checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
        checkOutput("rst_waddr", 32'(write_addr), 32'd0);
        checkOutput("rst_wdata", write_data, 32'd0);
        checkOutput("rst_reterr", 32'(ret_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single load to r5 and RAW/WAW stall checks
        applyStimulus(1'b1, 1'b1, 4'd5, 4'd0);
        checkOutput("ld5_stall", 32'(issue_stall), 32'd0);
        tick();
        checkOutput("ld5_pending", 32'(pending), 32'h0020);
        checkOutput("ld5_outstanding", 32'(outstanding), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd5);
        checkOutput("raw_r5_stall", 32'(issue_stall), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
        checkOutput("src0_stall", 32'(issue_stall), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd6);
        checkOutput("src6_stall", 32'(issue_stall), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'd5, 4'd0);
        checkOutput("waw_r5_stall", 32'(issue_stall), 32'd1);

        // Return to r5 while the dependent instruction waits
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd5);
        setReturn(1'b1, 4'd5, 32'hDEADBEEF);
        #1;
        checkOutput("ret5_ready", 32'(ld_ret_ready), 32'd1);
        checkOutput("ret5_stall_same_cycle", 32'(issue_stall), 32'd1);
        tick();
        setReturn(1'b0, 4'd0, 32'd0);
        #1;
        checkOutput("ret5_waddr", 32'(write_addr), 32'd5);
        checkOutput("ret5_wdata", write_data, 32'hDEADBEEF);
        checkOutput("ret5_pending", 32'(pending), 32'h0);
        checkOutput("ret5_unstall", 32'(issue_stall), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
        tick();
        checkOutput("idle_waddr", 32'(write_addr), 32'd0);

        // Fill the load budget with r1..r4, then a fifth load to r6
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b1, 4'(i), 4'd0);
            tick();
        end
        checkOutput("full_pending", 32'(pending), 32'h001E);
        checkOutput("full_outstanding", 32'(outstanding), 32'd4);
        applyStimulus(1'b1, 1'b1, 4'd6, 4'd0);
        checkOutput("cap_stall", 32'(issue_stall), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'd6, 4'd0);
        checkOutput("cap_nonload_stall", 32'(issue_stall), 32'd0);
        applyStimulus(1'b1, 1'b1, 4'd6, 4'd0);
        setReturn(1'b1, 4'd1, 32'h11);
        #1;
        checkOutput("cap_stall_with_ret", 32'(issue_stall), 32'd1);
        tick();
        setReturn(1'b0, 4'd0, 32'd0);
        #1;
        checkOutput("cap_outstanding3", 32'(outstanding), 32'd3);
        checkOutput("cap_unstall", 32'(issue_stall), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
        checkOutput("ld6_pending", 32'(pending), 32'h005C);
        checkOutput("ld6_outstanding", 32'(outstanding), 32'd4);

        // Contention: expect load, ALU, load, ALU
        setReturn(1'b1, 4'd2, 32'hA2);
        setAlu(1'b1, 4'd7, 32'h77);
        #1;
        checkOutput("arb1_ld_ready", 32'(ld_ret_ready), 32'd1);
        checkOutput("arb1_alu_ready", 32'(alu_wb_ready), 32'd0);
        tick();
        checkOutput("arb1_waddr", 32'(write_addr), 32'd2);
        setReturn(1'b1, 4'd3, 32'hA3);
        #1;
        checkOutput("arb2_ld_ready", 32'(ld_ret_ready), 32'd0);
        checkOutput("arb2_alu_ready", 32'(alu_wb_ready), 32'd1);
        tick();
        checkOutput("arb2_waddr", 32'(write_addr), 32'd7);
        checkOutput("arb2_wdata", write_data, 32'h77);
        setAlu(1'b1, 4'd8, 32'h88);
        #1;
        checkOutput("arb3_ld_ready", 32'(ld_ret_ready), 32'd1);
        tick();
        checkOutput("arb3_waddr", 32'(write_addr), 32'd3);
        setReturn(1'b1, 4'd4, 32'hA4);
        #1;
        checkOutput("arb4_alu_ready", 32'(alu_wb_ready), 32'd1);
        tick();
        setReturn(1'b0, 4'd0, 32'd0);
        setAlu(1'b0, 4'd0, 32'd0);
        checkOutput("arb4_waddr", 32'(write_addr), 32'd8);
        checkOutput("arb_pending", 32'(pending), 32'h0050);
        checkOutput("arb_outstanding", 32'(outstanding), 32'd2);

        // Stray return to r9, then a return to r0
        setReturn(1'b1, 4'd9, 32'h99);
        tick();
        setReturn(1'b0, 4'd0, 32'd0);
        checkOutput("r9_reterr", 32'(ret_err), 32'd1);
        checkOutput("r9_waddr", 32'(write_addr), 32'd9);
        checkOutput("r9_outstanding", 32'(outstanding), 32'd1);
        tick();
        checkOutput("r9_reterr_sticky", 32'(ret_err), 32'd1);
        setReturn(1'b1, 4'd0, 32'h55);
        tick();
        setReturn(1'b0, 4'd0, 32'd0);
        checkOutput("r0_waddr", 32'(write_addr), 32'd0);
        checkOutput("r0_outstanding", 32'(outstanding), 32'd0);
        checkOutput("r0_pending", 32'(pending), 32'h0050);

        // Mid-flight reset with three loads outstanding
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b1, 4'(i), 4'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
        checkOutput("pre_rst_outstanding", 32'(outstanding), 32'd3);
        checkOutput("pre_rst_pending", 32'(pending), 32'h000E);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_pending", 32'(pending), 32'h0);
        checkOutput("async_rst_outstanding", 32'(outstanding), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_pending", 32'(pending), 32'h0);
        checkOutput("post_rst_outstanding", 32'(outstanding), 32'd0);
        checkOutput("post_rst_reterr", 32'(ret_err), 32'd0);
        setReturn(1'b1, 4'd1, 32'h1);
        tick();
        setReturn(1'b0, 4'd0, 32'd0);
        checkOutput("late_ret_reterr", 32'(ret_err), 32'd1);
        checkOutput("late_ret_saturate", 32'(outstanding), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
